// File: rtl/mips_reg_dump.sv
// mips_reg_dump
// -------------
// Register-file read-out engine for the pipelined MIPS core. On a rising
// edge of the CPU halted flag, or on a one-cycle dump_req pulse, it walks
// registers R0..R(NUM_REGS-1) through the register-file read port and sends
// them as a framed byte stream on a valid/ready interface:
//   HDR_BYTE, NUM_REGS, { index, data[31:24], [23:16], [15:8], [7:0] } x N,
//   checksum (mod-256 sum of every byte after the header).
//
// Ports
//   clk1      in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   halted    in   CPU halted flag (level)
//   dump_req  in   one-cycle manual dump trigger
//   rf_raddr  out  register-file read address
//   rf_rdata  in   register-file read data (combinational from rf_raddr)
//   tx_data   out  stream byte
//   tx_valid  out  tx_data valid
//   tx_ready  in   sink accepts the byte
//   busy      out  high while a frame is in progress
//   done      out  one-cycle pulse after the checksum byte is accepted
module mips_reg_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        halted,
  input  logic        dump_req,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CNT  = 3'd2,
    S_RD   = 3'd3,
    S_IDX  = 3'd4,
    S_DATA = 3'd5,
    S_CSUM = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [7:0] CNT_BYTE = 8'(NUM_REGS);

  // Modulo-256 running checksum step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t      state_r, state_s;
  logic [4:0]  idx_r, idx_s;
  logic [1:0]  bcnt_r, bcnt_s;
  logic [7:0]  csum_r, csum_s;
  logic [31:0] shift_r, shift_s;
  logic        halted_q_r;
  logic [4:0]  rf_raddr_r, rf_raddr_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        tx_valid_r, tx_valid_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        trig_s;
  logic        accept_s;

  assign rf_raddr = rf_raddr_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Next-state, next-output and datapath logic for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    bcnt_s     = bcnt_r;
    shift_s    = shift_r;
    rf_raddr_s = rf_raddr_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    done_s     = 1'b0;
    trig_s     = (halted & ~halted_q_r) | dump_req;
    accept_s   = tx_valid_r & tx_ready;

    // Every accepted byte after the header feeds the checksum; the header
    // and checksum byte themselves never do.
    if (accept_s && ((state_r == S_CNT) || (state_r == S_IDX) || (state_r == S_DATA))) begin
      csum_s = csum_add(csum_r, tx_data_r);
    end else begin
      csum_s = csum_r;
    end

    case (state_r)
      S_IDLE: begin
        if (trig_s) begin
          state_s    = S_HDR;
          idx_s      = 5'd0;
          bcnt_s     = 2'd0;
          csum_s     = 8'd0;
          tx_valid_s = 1'b1;
          tx_data_s  = HDR_BYTE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (accept_s) begin
          state_s   = S_CNT;
          tx_data_s = CNT_BYTE;
        end else begin
          state_s = S_HDR;
        end
      end
      S_CNT: begin
        if (accept_s) begin
          state_s    = S_RD;
          tx_valid_s = 1'b0;
          rf_raddr_s = idx_r;
        end else begin
          state_s = S_CNT;
        end
      end
      S_RD: begin
        // Single sampling point for this register: later register-file
        // writes cannot disturb the bytes being sent.
        shift_s    = rf_rdata;
        state_s    = S_IDX;
        tx_valid_s = 1'b1;
        tx_data_s  = {3'b000, idx_r};
      end
      S_IDX: begin
        if (accept_s) begin
          state_s   = S_DATA;
          bcnt_s    = 2'd0;
          tx_data_s = shift_r[31:24];
        end else begin
          state_s = S_IDX;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          shift_s = {shift_r[23:0], 8'h00};
          if (bcnt_r == 2'd3) begin
            if (idx_r < LAST_IDX) begin
              idx_s      = idx_r + 5'd1;
              rf_raddr_s = idx_r + 5'd1;
              state_s    = S_RD;
              tx_valid_s = 1'b0;
            end else begin
              // csum_s already includes the byte accepted this cycle.
              state_s   = S_CSUM;
              tx_data_s = csum_s;
            end
          end else begin
            bcnt_s    = bcnt_r + 2'd1;
            tx_data_s = shift_r[23:16];
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          state_s    = S_DONE;
          tx_valid_s = 1'b0;
          done_s     = 1'b1;
        end else begin
          state_s = S_CSUM;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s    = S_IDLE;
        tx_valid_s = 1'b0;
      end
    endcase

    busy_s = (state_s != S_IDLE);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      idx_r      <= 5'd0;
      bcnt_r     <= 2'd0;
      csum_r     <= 8'd0;
      shift_r    <= 32'd0;
      halted_q_r <= 1'b1;
      rf_raddr_r <= 5'd0;
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      bcnt_r     <= bcnt_s;
      csum_r     <= csum_s;
      shift_r    <= shift_s;
      halted_q_r <= halted;
      rf_raddr_r <= rf_raddr_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

endmodule
